// File: rtl/bit_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_ser_pkg
// Purpose  : Shared types and constants for the bit serializer: FSM state
//            encoding, default word width and word counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bit_ser_pkg;

  // IDLE: shifter empty. SHIFT: a word is being emitted on bit_out.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int c_default_width = 8;
  localparam int c_word_cnt_w    = 16;

endpackage : bit_ser_pkg
`default_nettype wire

// File: rtl/ser_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : ser_hold_reg
// Purpose  : Single-entry holding register that parks one word while the
//            serializer is busy shifting the previous word.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset (empties the entry)
//            i_load   - capture i_data and mark the entry valid
//            i_clear  - empty the entry (its word has been consumed)
//            i_data   - word to capture
//            o_data   - held word
//            o_valid  - entry holds a word
// Revision : 1.0 - initial release
// ============================================================================
module ser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Load and clear never coincide in the serializer (load needs an empty
  // entry, clear needs a full one); clear wins should they ever both fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule : ser_hold_reg
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-to-serial converter with a one-word skid (hold)
//            register so back-to-back words stream with no idle cycles.
// Ports    : clk         - clock, all state updates on the rising edge
//            reset       - synchronous active-high reset
//            s_data      - parallel word to serialize
//            s_valid     - s_data is valid
//            s_ready     - a word can be accepted this cycle
//            bit_out     - serial data (0 when bit_valid is low)
//            bit_valid   - bit_out carries a live bit
//            frame_start - high while the first bit of a word is shown
//            word_count  - words fully shifted out (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer
  import bit_ser_pkg::*;
#(
  parameter int WIDTH     = c_default_width,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    frame_start,
  output logic [c_word_cnt_w-1:0] word_count
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  ser_state_t              r_state;
  logic [WIDTH-1:0]        r_shift;
  logic [CW-1:0]           r_bit_cnt;
  logic                    r_bit_out;
  logic                    r_bit_valid;
  logic                    r_frame_start;
  logic [c_word_cnt_w-1:0] r_word_count;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_hold_valid;
  logic [WIDTH-1:0]        w_hold_data;
  logic                    w_hold_load;
  logic                    w_hold_clear;
  logic                    w_load;
  logic [WIDTH-1:0]        w_load_data;
  logic [WIDTH-1:0]        w_shift_nx;

  // Bit that leaves the shifter first for a word (or shifted word).
  function automatic logic first_bit(input logic [WIDTH-1:0] x);
    return (MSB_FIRST != 0) ? x[WIDTH-1] : x[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] x);
    return (MSB_FIRST != 0) ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
  endfunction

  assign s_ready  = ~w_hold_valid & ~reset;
  assign w_accept = s_valid & s_ready;
  assign w_last   = (r_state == SHIFT) && (r_bit_cnt == C_LAST);

  // Mid-word accepts park in the hold register; on the last-bit edge a held
  // word takes precedence, otherwise a word offered on that same edge goes
  // straight into the shifter so the stream keeps running without a gap.
  assign w_hold_load  = (r_state == SHIFT) && !w_last && w_accept;
  assign w_hold_clear = w_last && w_hold_valid;
  assign w_load       = w_hold_clear || (w_accept && ((r_state == IDLE) || w_last));
  assign w_load_data  = w_hold_clear ? w_hold_data : s_data;
  assign w_shift_nx   = shift_one(r_shift);

  ser_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_data  (s_data),
    .o_data  (w_hold_data),
    .o_valid (w_hold_valid)
  );

  // r_bit_cnt indexes the bit currently presented on bit_out, so the output
  // registers are written together with the shifter on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_bit_out     <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_word_count  <= '0;
    end else begin
      if (w_last) begin
        r_word_count <= r_word_count + 16'd1;
      end
      if (w_load) begin
        r_state       <= SHIFT;
        r_shift       <= w_load_data;
        r_bit_cnt     <= '0;
        r_bit_out     <= first_bit(w_load_data);
        r_bit_valid   <= 1'b1;
        r_frame_start <= 1'b1;
      end else if ((r_state == SHIFT) && !w_last) begin
        r_shift       <= w_shift_nx;
        r_bit_cnt     <= r_bit_cnt + 1'b1;
        r_bit_out     <= first_bit(w_shift_nx);
        r_bit_valid   <= 1'b1;
        r_frame_start <= 1'b0;
      end else begin
        r_state       <= IDLE;
        r_bit_cnt     <= '0;
        r_bit_out     <= 1'b0;
        r_bit_valid   <= 1'b0;
        r_frame_start <= 1'b0;
      end
    end
  end

  assign bit_out     = r_bit_out;
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_frame_start;
  assign word_count  = r_word_count;

endmodule : bit_serializer
`default_nettype wire
